// File: rtl/qspi_flash_ctrl_if.sv
// Bundle of the SPI front-end, backing-memory and log signals around the flash
// command sequencer. The master side is the sequencer, the slave side is its environment.
interface qspi_flash_ctrl_if;
  logic        spi_cs;
  logic        spi_cmd_strobe;
  logic        spi_byte_strobe;
  logic [7:0]  spi_byte;
  logic [7:0]  spi_byte_tx;
  logic        mem_rd_req;
  logic [23:0] mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        log_valid;
  logic [7:0]  log_cmd;
  logic [23:0] log_addr;

  modport master (
    input  spi_cs, spi_cmd_strobe, spi_byte_strobe, spi_byte, mem_rd_ack, mem_rd_data,
    output spi_byte_tx, mem_rd_req, mem_addr, log_valid, log_cmd, log_addr
  );

  modport slave (
    output spi_cs, spi_cmd_strobe, spi_byte_strobe, spi_byte, mem_rd_ack, mem_rd_data,
    input  spi_byte_tx, mem_rd_req, mem_addr, log_valid, log_cmd, log_addr
  );
endinterface

// File: rtl/qspi_flash_ctrl.sv
// SPI flash emulator command sequencer: decodes opcodes, assembles the address,
// prefetches one byte ahead from backing memory and supplies the next byte to shift out.
module qspi_flash_ctrl #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter logic [7:0]  STATUS_REG = 8'h00,
  parameter logic [7:0]  IDLE_TX    = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  qspi_flash_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR2, ADDR1, ADDR0, DUMMY, READ, RDID, RDSR, IGNORE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  state_t      state_q, state_d;
  logic [7:0]  tx_q, tx_d;
  logic        req_q, req_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  pbuf_q, pbuf_d;
  logic        valid_q, valid_d;
  logic        loaded_q, loaded_d;
  logic        discard_q, discard_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] hi_q, hi_d;
  logic        logv_q, logv_d;
  logic [7:0]  logc_q, logc_d;
  logic [23:0] loga_q, loga_d;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    req_d     = req_q;
    addr_d    = addr_q;
    pbuf_d    = pbuf_q;
    valid_d   = valid_q;
    loaded_d  = loaded_q;
    discard_d = discard_q;
    idx_d     = idx_q;
    op_d      = op_q;
    hi_d      = hi_q;
    logv_d    = 1'b0;
    logc_d    = logc_q;
    loga_d    = loga_q;

    // A return for a transaction the host has already abandoned is dropped.
    if (bus.mem_rd_ack && req_q) begin
      req_d = 1'b0;
      if (discard_q || bus.spi_cs) begin
        discard_d = 1'b0;
      end else begin
        pbuf_d  = bus.mem_rd_data;
        valid_d = 1'b1;
        addr_d  = addr_q + 24'd1;
      end
    end

    if (bus.spi_cs) begin
      state_d   = IDLE;
      tx_d      = IDLE_TX;
      idx_d     = 2'd0;
      valid_d   = 1'b0;
      loaded_d  = 1'b0;
      discard_d = req_d;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.spi_cmd_strobe && bus.spi_byte_strobe) begin
            logc_d = bus.spi_byte;
            loga_d = 24'd0;
            if (bus.spi_byte == OP_READ || bus.spi_byte == OP_FAST_READ) begin
              op_d    = bus.spi_byte;
              state_d = ADDR2;
            end else if (bus.spi_byte == OP_RDID) begin
              state_d = RDID;
              tx_d    = JEDEC_ID[23:16];
              idx_d   = 2'd0;
              logv_d  = 1'b1;
            end else if (bus.spi_byte == OP_RDSR) begin
              state_d = RDSR;
              tx_d    = STATUS_REG;
              logv_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              tx_d    = IDLE_TX;
              logv_d  = 1'b1;
            end
          end
        end
        ADDR2: if (bus.spi_byte_strobe) begin
          hi_d[15:8] = bus.spi_byte;
          state_d    = ADDR1;
        end
        ADDR1: if (bus.spi_byte_strobe) begin
          hi_d[7:0] = bus.spi_byte;
          state_d   = ADDR0;
        end
        ADDR0: if (bus.spi_byte_strobe) begin
          addr_d   = {hi_q, bus.spi_byte};
          req_d    = 1'b1;
          valid_d  = 1'b0;
          loaded_d = 1'b0;
          logv_d   = 1'b1;
          logc_d   = op_q;
          loga_d   = {hi_q, bus.spi_byte};
          state_d  = (op_q == OP_FAST_READ) ? DUMMY : READ;
        end
        DUMMY: if (bus.spi_byte_strobe) state_d = READ;
        READ: begin
          // First byte of the data phase is pushed out as soon as it lands; later
          // bytes are handed over on each host strobe.
          if (valid_q && (bus.spi_byte_strobe || !loaded_q)) begin
            tx_d     = pbuf_q;
            valid_d  = 1'b0;
            req_d    = 1'b1;
            loaded_d = 1'b1;
          end else if (bus.spi_byte_strobe) begin
            tx_d     = IDLE_TX;
            loaded_d = 1'b1;
          end
        end
        RDID: if (bus.spi_byte_strobe) begin
          unique case (idx_q)
            2'd0:    begin tx_d = JEDEC_ID[15:8]; idx_d = 2'd1; end
            2'd1:    begin tx_d = JEDEC_ID[7:0];  idx_d = 2'd2; end
            default: begin tx_d = 8'h00;          idx_d = 2'd2; end
          endcase
        end
        RDSR:    tx_d = STATUS_REG;
        IGNORE:  tx_d = IDLE_TX;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= IDLE_TX;
      req_q     <= 1'b0;
      addr_q    <= 24'd0;
      valid_q   <= 1'b0;
      loaded_q  <= 1'b0;
      discard_q <= 1'b0;
      idx_q     <= 2'd0;
      logv_q    <= 1'b0;
      logc_q    <= 8'd0;
      loga_q    <= 24'd0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      loaded_q  <= loaded_d;
      discard_q <= discard_d;
      idx_q     <= idx_d;
      logv_q    <= logv_d;
      logc_q    <= logc_d;
      loga_q    <= loga_d;
    end
    pbuf_q <= pbuf_d;
    op_q   <= op_d;
    hi_q   <= hi_d;
  end

  assign bus.spi_byte_tx = tx_q;
  assign bus.mem_rd_req  = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.log_valid   = logv_q;
  assign bus.log_cmd     = logc_q;
  assign bus.log_addr    = loga_q;
endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Directed bench for qspi_flash_ctrl: host byte driver, delayed-ack memory
// responder, and one task per scenario with hand-computed expectations.
module tb_qspi_flash_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  qspi_flash_ctrl_if bus();

  qspi_flash_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_dly = 2;
  int req_cycles = 0;
  int addr_glitch = 0;
  logic [23:0] req_log[$];

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h001234: return 8'hA5;
      24'h001235: return 8'h5A;
      24'h001236: return 8'h3C;
      24'hFFFFFF: return 8'h11;
      24'h000000: return 8'h22;
      default:    return a[7:0] ^ 8'h5C;
    endcase
  endfunction

  // Memory responder: ack arrives ack_dly clocks after the request is seen.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_rd_ack) bus.mem_rd_ack = 1'b0;
      else if (bus.mem_rd_req && !reset) begin
        cnt++;
        if (cnt >= ack_dly) begin
          bus.mem_rd_ack  = 1'b1;
          bus.mem_rd_data = mem_val(bus.mem_addr);
          req_log.push_back(bus.mem_addr);
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  initial begin
    logic        prev_req;
    logic [23:0] prev_addr;
    prev_req  = 1'b0;
    prev_addr = 24'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_req) req_cycles++;
      if (bus.mem_rd_req && prev_req && bus.mem_addr !== prev_addr) addr_glitch++;
      prev_req  = bus.mem_rd_req;
      prev_addr = bus.mem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic first);
    @(posedge clk); #1;
    bus.spi_byte        = b;
    bus.spi_byte_strobe = 1'b1;
    bus.spi_cmd_strobe  = first;
    @(posedge clk); #1;
    bus.spi_byte_strobe = 1'b0;
    bus.spi_cmd_strobe  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.spi_cs = 1'b1;
    idle(3);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL rst_tx got=%h exp=ff", bus.spi_byte_tx); end
    total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.mem_rd_req); end
    total++; if (bus.mem_addr !== 24'h0) begin bad++; $display("FAIL rst_addr got=%h exp=000000", bus.mem_addr); end
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL rst_logv got=%b exp=0", bus.log_valid); end
    total++; if (bus.log_cmd !== 8'h0 || bus.log_addr !== 24'h0) begin bad++; $display("FAIL rst_log got=%h/%h exp=00/000000", bus.log_cmd, bus.log_addr); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_read;
    int base;
    base = req_log.size();
    ack_dly = 2;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h03, 1'b1); send(8'h00, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
    total++; if (bus.log_valid !== 1'b1 || bus.log_cmd !== 8'h03 || bus.log_addr !== 24'h001234) begin bad++; $display("FAIL read_log got=%b/%h/%h exp=1/03/001234", bus.log_valid, bus.log_cmd, bus.log_addr); end
    total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 24'h001234) begin bad++; $display("FAIL read_req got=%b/%h exp=1/001234", bus.mem_rd_req, bus.mem_addr); end
    idle(1);
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL read_logpulse got=%b exp=0", bus.log_valid); end
    idle(5);
    total++; if (bus.spi_byte_tx !== 8'hA5) begin bad++; $display("FAIL read_b0 got=%h exp=a5", bus.spi_byte_tx); end
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h5A) begin bad++; $display("FAIL read_b1 got=%h exp=5a", bus.spi_byte_tx); end
    idle(6);
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h3C) begin bad++; $display("FAIL read_b2 got=%h exp=3c", bus.spi_byte_tx); end
    idle(2);
    total++; if (req_log.size() < base + 3) begin bad++; $display("FAIL read_nreq got=%0d exp>=%0d", req_log.size() - base, 3); end
    else if (req_log[base] !== 24'h001234 || req_log[base+1] !== 24'h001235 || req_log[base+2] !== 24'h001236) begin
      bad++; $display("FAIL read_addrseq got=%h,%h,%h exp=001234,001235,001236", req_log[base], req_log[base+1], req_log[base+2]);
    end
    bus.spi_cs = 1'b1;
    idle(6);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL read_cs_tx got=%h exp=ff", bus.spi_byte_tx); end
  endtask

  task automatic test_fast_read_wrap;
    int base;
    base = req_log.size();
    ack_dly = 2;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h0B, 1'b1); send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    total++; if (bus.log_cmd !== 8'h0B || bus.log_addr !== 24'hFFFFFF || bus.mem_addr !== 24'hFFFFFF) begin bad++; $display("FAIL fast_log got=%h/%h/%h exp=0b/ffffff/ffffff", bus.log_cmd, bus.log_addr, bus.mem_addr); end
    idle(6);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL fast_predummy got=%h exp=ff", bus.spi_byte_tx); end
    total++; if (bus.mem_addr !== 24'h000000 || bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL fast_wrap got=%h/%b exp=000000/0", bus.mem_addr, bus.mem_rd_req); end
    send(8'hAA, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL fast_dummy got=%h exp=ff", bus.spi_byte_tx); end
    idle(1);
    total++; if (bus.spi_byte_tx !== 8'h11) begin bad++; $display("FAIL fast_b0 got=%h exp=11", bus.spi_byte_tx); end
    total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 24'h000000) begin bad++; $display("FAIL fast_req2 got=%b/%h exp=1/000000", bus.mem_rd_req, bus.mem_addr); end
    idle(6);
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h22) begin bad++; $display("FAIL fast_b1 got=%h exp=22", bus.spi_byte_tx); end
    idle(2);
    total++; if (req_log.size() < base + 2) begin bad++; $display("FAIL fast_nreq got=%0d exp>=2", req_log.size() - base); end
    else if (req_log[base] !== 24'hFFFFFF || req_log[base+1] !== 24'h000000) begin bad++; $display("FAIL fast_addrseq got=%h,%h exp=ffffff,000000", req_log[base], req_log[base+1]); end
    bus.spi_cs = 1'b1;
    idle(6);
  endtask

  task automatic test_rdid;
    int rc;
    logic [7:0] exp_tx [3];
    exp_tx = '{8'h40, 8'h18, 8'h00};
    rc = req_cycles;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h9F, 1'b1);
    total++; if (bus.spi_byte_tx !== 8'hEF) begin bad++; $display("FAIL rdid_b0 got=%h exp=ef", bus.spi_byte_tx); end
    total++; if (bus.log_valid !== 1'b1 || bus.log_cmd !== 8'h9F || bus.log_addr !== 24'h0) begin bad++; $display("FAIL rdid_log got=%b/%h/%h exp=1/9f/000000", bus.log_valid, bus.log_cmd, bus.log_addr); end
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 1'b0);
      total++; if (bus.spi_byte_tx !== exp_tx[i]) begin bad++; $display("FAIL rdid_b%0d got=%h exp=%h", i + 1, bus.spi_byte_tx, exp_tx[i]); end
    end
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h00) begin bad++; $display("FAIL rdid_b4 got=%h exp=00", bus.spi_byte_tx); end
    total++; if (req_cycles !== rc) begin bad++; $display("FAIL rdid_noreq got=%0d exp=%0d", req_cycles, rc); end
    bus.spi_cs = 1'b1;
    idle(3);
  endtask

  task automatic test_ignore_rdsr;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h06, 1'b1);
    total++; if (bus.spi_byte_tx !== 8'hFF || bus.log_valid !== 1'b1 || bus.log_cmd !== 8'h06 || bus.log_addr !== 24'h0) begin bad++; $display("FAIL ign_cmd got=%h/%b/%h/%h exp=ff/1/06/000000", bus.spi_byte_tx, bus.log_valid, bus.log_cmd, bus.log_addr); end
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL ign_b1 got=%h exp=ff", bus.spi_byte_tx); end
    bus.spi_cs = 1'b1;
    idle(3);
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h05, 1'b1);
    total++; if (bus.spi_byte_tx !== 8'h00 || bus.log_cmd !== 8'h05) begin bad++; $display("FAIL rdsr_cmd got=%h/%h exp=00/05", bus.spi_byte_tx, bus.log_cmd); end
    for (int i = 0; i < 2; i++) begin
      send(8'h00, 1'b0);
      total++; if (bus.spi_byte_tx !== 8'h00) begin bad++; $display("FAIL rdsr_b%0d got=%h exp=00", i, bus.spi_byte_tx); end
    end
    bus.spi_cs = 1'b1;
    idle(3);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL rdsr_cs got=%h exp=ff", bus.spi_byte_tx); end
  endtask

  task automatic test_abort_and_reset;
    ack_dly = 10;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h03, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h40, 1'b0);
    idle(2);
    bus.spi_cs = 1'b1;
    idle(2);
    total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 24'h000040) begin bad++; $display("FAIL abort_hold got=%b/%h exp=1/000040", bus.mem_rd_req, bus.mem_addr); end
    for (int i = 0; i < 30 && bus.mem_rd_req; i++) idle(1);
    total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL abort_ack_timeout got=%b exp=0", bus.mem_rd_req); end
    idle(2);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL abort_tx got=%h exp=ff", bus.spi_byte_tx); end
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h05, 1'b1);
    total++; if (bus.spi_byte_tx !== 8'h00 || bus.log_cmd !== 8'h05) begin bad++; $display("FAIL abort_idle got=%h/%h exp=00/05", bus.spi_byte_tx, bus.log_cmd); end
    bus.spi_cs = 1'b1;
    idle(3);
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h03, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h80, 1'b0);
    idle(2);
    total++; if (bus.mem_rd_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", bus.mem_rd_req); end
    reset = 1'b1;
    idle(1);
    total++; if (bus.mem_rd_req !== 1'b0 || bus.mem_addr !== 24'h0) begin bad++; $display("FAIL rstmid_req got=%b/%h exp=0/000000", bus.mem_rd_req, bus.mem_addr); end
    total++; if (bus.spi_byte_tx !== 8'hFF || bus.log_cmd !== 8'h00) begin bad++; $display("FAIL rstmid_tx got=%h/%h exp=ff/00", bus.spi_byte_tx, bus.log_cmd); end
    bus.spi_cs = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_back_to_back;
    int base;
    base = req_log.size();
    ack_dly = 4;
    bus.spi_cs = 1'b0;
    idle(2);
    send(8'h03, 1'b1); send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0);
    idle(10);
    total++; if (bus.spi_byte_tx !== 8'h5C) begin bad++; $display("FAIL b2b_b0 got=%h exp=5c", bus.spi_byte_tx); end
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h5D) begin bad++; $display("FAIL b2b_b1 got=%h exp=5d", bus.spi_byte_tx); end
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'hFF) begin bad++; $display("FAIL b2b_underrun got=%h exp=ff", bus.spi_byte_tx); end
    total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 24'h000102) begin bad++; $display("FAIL b2b_onereq got=%b/%h exp=1/000102", bus.mem_rd_req, bus.mem_addr); end
    idle(6);
    send(8'h00, 1'b0);
    total++; if (bus.spi_byte_tx !== 8'h5E || bus.mem_addr !== 24'h000103) begin bad++; $display("FAIL b2b_b2 got=%h/%h exp=5e/000103", bus.spi_byte_tx, bus.mem_addr); end
    idle(6);
    total++; if (req_log.size() < base + 3) begin bad++; $display("FAIL b2b_nreq got=%0d exp>=3", req_log.size() - base); end
    else if (req_log[base] !== 24'h000100 || req_log[base+1] !== 24'h000101 || req_log[base+2] !== 24'h000102) begin
      bad++; $display("FAIL b2b_addrseq got=%h,%h,%h exp=000100,000101,000102", req_log[base], req_log[base+1], req_log[base+2]);
    end
    bus.spi_cs = 1'b1;
    idle(8);
  endtask

  initial begin
    bus.spi_cs          = 1'b1;
    bus.spi_cmd_strobe  = 1'b0;
    bus.spi_byte_strobe = 1'b0;
    bus.spi_byte        = 8'h00;
    test_reset();
    test_read();
    test_fast_read_wrap();
    test_rdid();
    test_ignore_rdsr();
    test_abort_and_reset();
    test_back_to_back();
    total++; if (addr_glitch !== 0) begin bad++; $display("FAIL addr_stable got=%0d exp=0", addr_glitch); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qspi_flash_ctrl.md
Name: qspi_flash_ctrl

Overview:
- Command sequencer for the single-lane SPI flash emulator, running entirely in the clk domain.
- Consumes the synchronized chip-select, command strobe, byte strobe and received byte from the qspi_sync front end.
- Decodes flash commands, assembles the 24-bit address and issues one-byte read requests to the backing memory, prefetching ahead of the host.
- Drives the transmit byte that the front end shifts out, and emits a per-transaction log pulse for the USB monitor.

Parameters:
- JEDEC_ID, 24'hEF4018, bytes returned by RDID (0x9F), MSB first.
- STATUS_REG, 8'h00, byte returned repeatedly by RDSR (0x05).
- IDLE_TX, 8'hFF, transmit byte when no data is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_cs  in  1  synchronized chip select; high means deselected.
- spi_cmd_strobe  in  1  one-clk pulse: first byte of the transaction received.
- spi_byte_strobe  in  1  one-clk pulse: any byte received, including the first.
- spi_byte  in  8  received byte, valid on spi_byte_strobe.
- spi_byte_tx  out  8  next byte to shift out to the host.
- mem_rd_req  out  1  memory read request, level signal.
- mem_addr  out  24  read address, stable while mem_rd_req is high.
- mem_rd_ack  in  1  one-clk pulse: mem_rd_data valid.
- mem_rd_data  in  8  read data.
- log_valid  out  1  one-clk pulse: command (and address, if any) decoded.
- log_cmd  out  8  command opcode, valid with log_valid.
- log_addr  out  24  start address, valid with log_valid; 0 for non-address commands.

Behaviour:
- Reset values: spi_byte_tx=IDLE_TX, mem_rd_req=0, mem_addr=0, log_valid=0, log_cmd=0, log_addr=0, state=IDLE.
- States: IDLE, ADDR2, ADDR1, ADDR0, DUMMY, READ, RDID, RDSR, IGNORE.
- spi_cs high on any clk: next state IDLE, spi_byte_tx=IDLE_TX, id index=0, prefetch buffer invalidated. This overrides any simultaneous strobe.
- IDLE on spi_cmd_strobe with spi_byte_strobe:
  - 0x03 (READ) or 0x0B (FAST_READ): latch opcode, go to ADDR2.
  - 0x9F: go to RDID; spi_byte_tx=JEDEC_ID[23:16] the next clk; log_valid pulses.
  - 0x05: go to RDSR; spi_byte_tx=STATUS_REG; log_valid pulses.
  - Any other opcode: go to IGNORE; spi_byte_tx=IDLE_TX; log_valid pulses.
- ADDR2/ADDR1/ADDR0: each spi_byte_strobe shifts spi_byte into address bits [23:16], [15:8], [7:0] respectively.
- On the ADDR0 strobe: go to READ for 0x03, or DUMMY for 0x0B. The same clk sets mem_addr=assembled address and mem_rd_req=1, and pulses log_valid with log_addr=address.
- DUMMY: the next spi_byte_strobe goes to READ; the dummy byte content is ignored.
- Prefetch: one-byte buffer plus a valid flag.
  - On mem_rd_ack: buffer=mem_rd_data, valid=1, mem_rd_req=0, mem_addr=mem_addr+1 (24-bit wrap, 0xFFFFFF→0x000000).
  - If spi_byte_tx has not yet been loaded for this data phase, the buffer moves to spi_byte_tx in the ack clk +1 and a new request issues.
- READ: each spi_byte_strobe while valid=1 loads spi_byte_tx=buffer, sets valid=0 and raises mem_rd_req for the next address the following clk. At most one request is outstanding.
- Underrun (strobe while valid=0): spi_byte_tx=IDLE_TX; the outstanding request continues.
- Handshake: mem_rd_req stays high, with mem_addr stable, until mem_rd_ack. If spi_cs rises while a request is outstanding, the request holds until ack and the returned data is discarded.
- Synchronous reset drops mem_rd_req immediately, regardless of handshake state.
- RDID: each spi_byte_strobe advances the index. spi_byte_tx sequence: JEDEC_ID[15:8], then JEDEC_ID[7:0], then 8'h00 forever.
- RDSR: spi_byte_tx stays STATUS_REG for the rest of the transaction.
- IGNORE: no memory traffic; spi_byte_tx=IDLE_TX until spi_cs high.
- spi_cmd_strobe outside IDLE is ignored. The front end pulses it only once per transaction.
- Latency: spi_byte_tx updates 1 clk after the strobe or ack that causes it. Host SPI clock rate must leave at least memory latency + 3 clk per byte.

Test Plan:
- READ 0x03, address 0x001234, mem returns 0xA5,0x5A,0x3C (ack 2 clk after each req) → log_valid with cmd 0x03/addr 0x001234; mem_addr sequence 0x001234, 0x001235, 0x001236; spi_byte_tx A5,5A,3C on successive byte strobes.
- FAST_READ 0x0B, address 0xFFFFFF, one dummy byte, 2 data bytes → second request at mem_addr 0x000000; first data byte appears only after the dummy strobe.
- RDID 0x9F then 3 byte strobes → spi_byte_tx EF, 40, 18, then 00; mem_rd_req never asserts.
- Opcode 0x06, then cs high, then RDSR 0x05 with 2 strobes → FF during 0x06; log_cmd 0x06 then 0x05; spi_byte_tx=00 for both RDSR bytes.
- READ with mem ack delayed 10 clk; cs rises before ack → req held until ack, data discarded, state IDLE, spi_byte_tx=FF; reset asserted mid-request in a repeat run → mem_rd_req=0 next clk.
- Back-to-back byte strobes faster than memory → underrun yields FF, no second outstanding request, address continues incrementing correctly.
